// File: rtl/seq_magnitude_comparator_if.sv
// Request/response bundle for seq_magnitude_comparator.
// The master modport issues compares and the slave modport is the comparator.
interface seq_magnitude_comparator_if #(
  parameter int W = 8
);
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         is_signed;
  logic         ready;
  logic         done;
  logic         agtb;
  logic         aeqb;
  logic         altb;

  modport master (
    output start, a, b, is_signed,
    input  ready, done, agtb, aeqb, altb
  );

  modport slave (
    input  start, a, b, is_signed,
    output ready, done, agtb, aeqb, altb
  );
endinterface

// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle W-bit magnitude comparator that walks D-bit chunks MSB-first and
// stops at the first chunk that differs. Flags are registered and held between results.
module seq_magnitude_comparator #(
  parameter int W = 8,
  parameter int D = 1
) (
  input logic                      clk,
  input logic                      reset_n,
  seq_magnitude_comparator_if.slave bus
);

  localparam int N  = W / D;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [W-1:0]  opA_q, opA_d;
  logic [W-1:0]  opB_q, opB_d;
  logic [CW-1:0] chunkIdx_q, chunkIdx_d;
  logic          gt_q, gt_d;
  logic          eq_q, eq_d;
  logic          lt_q, lt_d;

  logic [W-1:0]  signFlip;
  logic [D-1:0]  chunkA;
  logic [D-1:0]  chunkB;

  // Flipping the sign bit maps two's-complement order onto unsigned order.
  assign signFlip = {bus.is_signed, {(W-1){1'b0}}};

  // Operands shift left as chunks are consumed, so the chunk under test is
  // always the top D bits and no wide variable-index mux is needed.
  assign chunkA = opA_q[W-1 -: D];
  assign chunkB = opB_q[W-1 -: D];

  always_comb begin
    state_d    = state_q;
    opA_d      = opA_q;
    opB_d      = opB_q;
    chunkIdx_d = chunkIdx_q;
    gt_d       = gt_q;
    eq_d       = eq_q;
    lt_d       = lt_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          opA_d      = bus.a ^ signFlip;
          opB_d      = bus.b ^ signFlip;
          chunkIdx_d = CW'(N - 1);
          state_d    = S_RUN;
        end
      end

      S_RUN: begin
        if (chunkA != chunkB) begin
          gt_d    = (chunkA > chunkB);
          lt_d    = (chunkA < chunkB);
          eq_d    = 1'b0;
          state_d = S_DONE;
        end else if (chunkIdx_q == '0) begin
          gt_d    = 1'b0;
          lt_d    = 1'b0;
          eq_d    = 1'b1;
          state_d = S_DONE;
        end else begin
          chunkIdx_d = chunkIdx_q - CW'(1);
          opA_d      = opA_q << D;
          opB_d      = opB_q << D;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      opA_q      <= '0;
      opB_q      <= '0;
      chunkIdx_q <= '0;
      gt_q       <= 1'b0;
      eq_q       <= 1'b0;
      lt_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      opA_q      <= opA_d;
      opB_q      <= opB_d;
      chunkIdx_q <= chunkIdx_d;
      gt_q       <= gt_d;
      eq_q       <= eq_d;
      lt_q       <= lt_d;
    end
  end

  assign bus.ready = (state_q == S_IDLE);
  assign bus.done  = (state_q == S_DONE);
  assign bus.agtb  = gt_q;
  assign bus.aeqb  = eq_q;
  assign bus.altb  = lt_q;

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Bench for seq_magnitude_comparator: five width/chunk configurations share one
// stimulus stream and are checked every cycle against an arithmetic reference model.
module tb_seq_magnitude_comparator;

  logic       clk;
  logic       reset_n;
  logic       startIn;
  logic [7:0] aIn;
  logic [7:0] bIn;
  logic       sgnIn;
  logic       checkOn;

  int vecCount;
  int missCount;

  seq_magnitude_comparator_if #(.W(8)) if81 ();
  seq_magnitude_comparator_if #(.W(8)) if82 ();
  seq_magnitude_comparator_if #(.W(8)) if84 ();
  seq_magnitude_comparator_if #(.W(4)) if41 ();
  seq_magnitude_comparator_if #(.W(4)) if42 ();

  assign if81.start = startIn;  assign if81.a = aIn;       assign if81.b = bIn;       assign if81.is_signed = sgnIn;
  assign if82.start = startIn;  assign if82.a = aIn;       assign if82.b = bIn;       assign if82.is_signed = sgnIn;
  assign if84.start = startIn;  assign if84.a = aIn;       assign if84.b = bIn;       assign if84.is_signed = sgnIn;
  assign if41.start = startIn;  assign if41.a = aIn[3:0];  assign if41.b = bIn[3:0];  assign if41.is_signed = sgnIn;
  assign if42.start = startIn;  assign if42.a = aIn[3:0];  assign if42.b = bIn[3:0];  assign if42.is_signed = sgnIn;

  seq_magnitude_comparator #(.W(8), .D(1)) u81 (.clk(clk), .reset_n(reset_n), .bus(if81.slave));
  seq_magnitude_comparator #(.W(8), .D(2)) u82 (.clk(clk), .reset_n(reset_n), .bus(if82.slave));
  seq_magnitude_comparator #(.W(8), .D(4)) u84 (.clk(clk), .reset_n(reset_n), .bus(if84.slave));
  seq_magnitude_comparator #(.W(4), .D(1)) u41 (.clk(clk), .reset_n(reset_n), .bus(if41.slave));
  seq_magnitude_comparator #(.W(4), .D(2)) u42 (.clk(clk), .reset_n(reset_n), .bus(if42.slave));

  logic [4:0] doneV, readyV, gtV, eqV, ltV;
  assign doneV  = {if42.done, if41.done, if84.done, if82.done, if81.done};
  assign readyV = {if42.ready, if41.ready, if84.ready, if82.ready, if81.ready};
  assign gtV    = {if42.agtb, if41.agtb, if84.agtb, if82.agtb, if81.agtb};
  assign eqV    = {if42.aeqb, if41.aeqb, if84.aeqb, if82.aeqb, if81.aeqb};
  assign ltV    = {if42.altb, if41.altb, if84.altb, if82.altb, if81.altb};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int wOf(input int i);
    return (i < 3) ? 8 : 4;
  endfunction

  function automatic int dOf(input int i);
    case (i)
      0: return 1;
      1: return 2;
      2: return 4;
      3: return 1;
      default: return 2;
    endcase
  endfunction

  // Reference: plain integer compare, latency from the highest differing bit.
  function automatic void refCompare(input int w, input int d, input logic [7:0] a,
                                     input logic [7:0] b, input logic s,
                                     output logic gt, output logic eq, output logic lt,
                                     output int n);
    int mask, ua, ub, sa, sb, p;
    mask = (1 << w) - 1;
    ua = int'(a) & mask;
    ub = int'(b) & mask;
    sa = ua;
    sb = ub;
    if (s) begin
      if (ua >= (1 << (w - 1))) sa = ua - (1 << w);
      if (ub >= (1 << (w - 1))) sb = ub - (1 << w);
    end
    gt = (sa > sb);
    eq = (sa == sb);
    lt = (sa < sb);
    p = -1;
    for (int k = w - 1; k >= 0; k--) begin
      if (p < 0 && (((ua ^ ub) >> k) & 1) == 1) p = k;
    end
    n = (p < 0) ? (w / d) : ((w - 1 - p) / d + 1);
  endfunction

  logic mBusy [5];
  int   mCnt  [5];
  int   mN    [5];
  logic mGt [5], mEq [5], mLt [5];
  logic pGt [5], pEq [5], pLt [5];
  logic rg, re, rl;
  int   rn;

  // Model tracks edges since acceptance; done is expected when that count reaches n.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 5; i++) begin
        mBusy[i] <= 1'b0;
        mCnt[i]  <= 0;
        mN[i]    <= 0;
        mGt[i]   <= 1'b0;  mEq[i] <= 1'b0;  mLt[i] <= 1'b0;
        pGt[i]   <= 1'b0;  pEq[i] <= 1'b0;  pLt[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (mBusy[i]) begin
          if (mCnt[i] == mN[i]) begin
            mBusy[i] <= 1'b0;
          end else begin
            mCnt[i] <= mCnt[i] + 1;
            if (mCnt[i] + 1 == mN[i]) begin
              mGt[i] <= pGt[i];
              mEq[i] <= pEq[i];
              mLt[i] <= pLt[i];
            end
          end
        end else if (startIn) begin
          refCompare(wOf(i), dOf(i), aIn, bIn, sgnIn, rg, re, rl, rn);
          mBusy[i] <= 1'b1;
          mCnt[i]  <= 0;
          mN[i]    <= rn;
          pGt[i]   <= rg;
          pEq[i]   <= re;
          pLt[i]   <= rl;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (checkOn && reset_n) begin
      for (int i = 0; i < 5; i++) begin
        vecCount++;
        if (doneV[i] !== (mBusy[i] && mCnt[i] == mN[i]) || readyV[i] !== !mBusy[i] ||
            {gtV[i], eqV[i], ltV[i]} !== {mGt[i], mEq[i], mLt[i]}) begin
          missCount++;
          $display("[TB] FAIL cycle inst%0d t=%0t: got done=%b ready=%b gel=%b%b%b, expected done=%b ready=%b gel=%b%b%b",
                   i, $time, doneV[i], readyV[i], gtV[i], eqV[i], ltV[i],
                   mBusy[i] && mCnt[i] == mN[i], !mBusy[i], mGt[i], mEq[i], mLt[i]);
        end
      end
    end
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    vecCount++;
    if (act != exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic waitIdle();
    int t;
    t = 0;
    while (readyV != 5'b11111 && t < 40) begin
      @(negedge clk);
      t++;
    end
    checkOutput("idleBeforeStart", int'(readyV), 31);
  endtask

  int latV [5];
  int flgV [5];

  // Issues one compare, optionally pulses a conflicting start while busy, and
  // records per-instance latency and flags at the done pulse.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                               input logic s, input int busyAt);
    int  m, n;
    logic g, e, l;
    logic allSeen;
    waitIdle();
    aIn = a;  bIn = b;  sgnIn = s;  startIn = 1'b1;
    @(posedge clk);
    @(negedge clk);
    startIn = 1'b0;
    for (int i = 0; i < 5; i++) begin
      latV[i] = 0;
      flgV[i] = 0;
    end
    m = 0;
    allSeen = 1'b0;
    while (!allSeen && m < 20) begin
      @(negedge clk);
      m++;
      if (m == busyAt) begin
        startIn = 1'b1;  aIn = 8'hFF;  bIn = 8'h00;
      end
      if (m == busyAt + 1) startIn = 1'b0;
      allSeen = 1'b1;
      for (int i = 0; i < 5; i++) begin
        if (doneV[i] && latV[i] == 0) begin
          latV[i] = m;
          flgV[i] = int'({gtV[i], eqV[i], ltV[i]});
        end
        if (latV[i] == 0) allSeen = 1'b0;
      end
    end
    startIn = 1'b0;
    for (int i = 0; i < 5; i++) begin
      refCompare(wOf(i), dOf(i), a, b, s, g, e, l, n);
      checkOutput($sformatf("lat i%0d a=%h b=%h s=%0d", i, a, b, s), latV[i], n);
      checkOutput($sformatf("flags i%0d a=%h b=%h s=%0d", i, a, b, s), flgV[i], int'({g, e, l}));
    end
  endtask

  initial begin
    int   firstDone, secondDone;
    logic [4:0] doneSeen;
    logic g, e, l;
    int   n;

    vecCount  = 0;
    missCount = 0;
    checkOn   = 1'b0;
    reset_n   = 1'b0;
    startIn   = 1'b0;
    aIn       = 8'h00;
    bIn       = 8'h00;
    sgnIn     = 1'b0;

    #12;
    checkOutput("resetReady", int'(readyV), 31);
    checkOutput("resetDone", int'(doneV), 0);
    checkOutput("resetFlags", int'({gtV, eqV, ltV}), 0);
    @(negedge clk);
    reset_n = 1'b1;
    checkOn = 1'b1;

    // Pin the reference model with hand-derived values.
    refCompare(4, 1, 8'h03, 8'h0C, 1'b1, g, e, l, n);
    checkOutput("refSignedFlags", int'({g, e, l}), 'b100);
    checkOutput("refSignedLat", n, 1);
    refCompare(8, 2, 8'hFF, 8'hFE, 1'b1, g, e, l, n);
    checkOutput("refLatD2", n, 4);

    $display("[TB] directed vectors");
    applyStimulus(8'h80, 8'h7F, 1'b0, 0);
    checkOutput("80v7F d1 lat", latV[0], 1);
    checkOutput("80v7F d1 flags", flgV[0], 'b100);

    applyStimulus(8'h5A, 8'h5A, 1'b0, 0);
    checkOutput("5Av5A d1 lat", latV[0], 8);
    checkOutput("5Av5A d1 flags", flgV[0], 'b010);
    checkOutput("5Av5A d4 lat", latV[2], 2);
    checkOutput("5Av5A d4 flags", flgV[2], 'b010);

    applyStimulus(8'h80, 8'h01, 1'b1, 0);
    checkOutput("80v01 signed d2 flags", flgV[1], 'b001);
    applyStimulus(8'h80, 8'h01, 1'b0, 0);
    checkOutput("80v01 unsigned d2 flags", flgV[1], 'b100);
    applyStimulus(8'hFF, 8'hFE, 1'b1, 0);
    checkOutput("FFvFE signed d2 flags", flgV[1], 'b100);
    checkOutput("FFvFE signed d2 lat", latV[1], 4);

    applyStimulus(8'h10, 8'h11, 1'b0, 2);
    checkOutput("busy 10v11 d1 lat", latV[0], 8);
    checkOutput("busy 10v11 d1 flags", flgV[0], 'b001);

    $display("[TB] continuous start");
    waitIdle();
    aIn = 8'h33;  bIn = 8'h31;  sgnIn = 1'b0;  startIn = 1'b1;
    @(posedge clk);
    firstDone  = -1;
    secondDone = -1;
    for (int m = 0; m < 30; m++) begin
      @(negedge clk);
      if (doneV[0]) begin
        if (firstDone < 0) firstDone = m;
        else if (secondDone < 0) secondDone = m;
      end
    end
    startIn = 1'b0;
    checkOutput("heldStart firstDone", firstDone, 7);
    checkOutput("heldStart interval", secondDone - firstDone, 9);

    $display("[TB] abort by reset");
    waitIdle();
    aIn = 8'h5A;  bIn = 8'h5A;  sgnIn = 1'b0;  startIn = 1'b1;
    @(posedge clk);
    @(negedge clk);
    startIn = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("abortReady", int'(readyV), 31);
    checkOutput("abortDone", int'(doneV), 0);
    checkOutput("abortFlags", int'({gtV, eqV, ltV}), 0);
    @(negedge clk);
    reset_n = 1'b1;
    doneSeen = '0;
    repeat (12) begin
      @(negedge clk);
      doneSeen = doneSeen | doneV;
    end
    checkOutput("noDoneAfterAbort", int'(doneSeen), 0);

    $display("[TB] exhaustive 4-bit sweep");
    for (int s = 0; s < 2; s++) begin
      for (int av = 0; av < 16; av++) begin
        for (int bv = 0; bv < 16; bv++) begin
          applyStimulus({4'(av), 4'(av)}, {4'(bv), 4'(bv)}, 1'(s), 0);
        end
      end
    end

    waitIdle();
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
